uart_tx_scheduler: RTL and testbench

//  Buffers bytes the CPU stores to the UART address and paces them into the uart

---
 rtl/uart_tx_scheduler_pkg.sv | 14 +
 rtl/uart_tx_scheduler_if.sv | 23 ++
 rtl/uart_tx_fifo.sv | 48 ++++
 rtl/uart_tx_scheduler.sv | 68 ++++++
 tb/tb_uart_tx_scheduler.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// State codes are fixed so they line up with existing debug tooling.
package uart_tx_scheduler_pkg;

    localparam int UTS_DEPTH         = 16;
    localparam int UART_FRAME_CYCLES = 8680;

    typedef enum logic [1:0] {
        UTS_IDLE = 2'd0,
        UTS_SEND = 2'd1,
        UTS_WAIT = 2'd2
    } uts_state_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Store-side and uart-side signals of the transmit scheduler.
interface uart_tx_scheduler_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              uart_wr_o;
    logic [7:0]        uart_dat_o;
    logic              tx_busy;

    modport master (
        output wr_en, wr_data,
        input  full, level, overflow, uart_wr_o, uart_dat_o, tx_busy
    );

    modport slave (
        input  wr_en, wr_data,
        output full, level, overflow, uart_wr_o, uart_dat_o, tx_busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous DEPTH x 8 FIFO; head is read combinationally so a pop
// can latch it in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_push, do_pop;

    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Buffers stored bytes and strobes them into the uart one frame at a time,
// since the uart itself has no busy indication.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int DEPTH        = UTS_DEPTH,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int FRAME_CYCLES = UART_FRAME_CYCLES
) (
    input  logic clk,
    input  logic rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_CYCLES);

    uts_state_e       state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             push, pop, empty;
    logic [7:0]       head;

    assign push = bus.wr_en & ~bus.full;
    assign pop  = (state == UTS_IDLE) & ~empty;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.wr_data),
        .dout  (head),
        .level (bus.level),
        .full  (bus.full),
        .empty (empty)
    );

    assign bus.tx_busy = ~empty | (state != UTS_IDLE);

    always_comb begin
        next_state = state;
        case (state)
            UTS_IDLE: if (!empty)      next_state = UTS_SEND;
            UTS_SEND:                  next_state = UTS_WAIT;
            UTS_WAIT: if (cnt == '0)   next_state = UTS_IDLE;
            default:                   next_state = UTS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= UTS_IDLE;
            cnt            <= '0;
            bus.overflow   <= 1'b0;
            bus.uart_wr_o  <= 1'b0;
            bus.uart_dat_o <= 8'h00;
        end else begin
            state         <= next_state;
            bus.uart_wr_o <= (next_state == UTS_SEND);
            if (pop) bus.uart_dat_o <= head;
            // SEND loads the frame budget; WAIT burns it down to zero
            if (state == UTS_SEND)
                cnt <= CNT_W'(FRAME_CYCLES - 1);
            else if (state == UTS_WAIT && cnt != '0)
                cnt <= cnt - CNT_W'(1);
            // a blocked push is lost even if a pop frees a slot this cycle
            if (bus.wr_en && bus.full) bus.overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized and scenario checks of uart_tx_scheduler against a timeline model.
module tb_uart_tx_scheduler;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int FRAME  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    uart_tx_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FRAME_CYCLES(FRAME)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model: queued bytes, edge at which the sender is next free to pop
    logic [7:0] m_q[$];
    int         m_idle_from = 0;
    int         m_pop_edge  = -1;
    logic [7:0] m_dat       = 8'h00;
    bit         m_ovf       = 1'b0;

    int         s_cyc[$];
    logic [7:0] s_byte[$];
    bit         busy_log[int];
    int         lvl_max;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic we, input logic [7:0] d, input logic r);
        bit do_pop, accept;
        if (r) begin
            m_q.delete();
            m_idle_from = 0;
            m_pop_edge  = -1;
            m_dat       = 8'h00;
            m_ovf       = 1'b0;
        end else begin
            do_pop = (cyc >= m_idle_from) && (m_q.size() > 0);
            accept = we && (m_q.size() < DEPTH);
            if (we && !accept) m_ovf = 1'b1;
            if (do_pop) begin
                m_dat       = m_q.pop_front();
                m_pop_edge  = cyc;
                // one pop cycle, one strobe cycle, FRAME wait cycles
                m_idle_from = cyc + FRAME + 2;
            end
            if (accept) m_q.push_back(d);
        end
    endtask

    task automatic step(input logic we, input logic [7:0] d, input logic r);
        bus.wr_en   = we;
        bus.wr_data = d;
        rst         = r;
        @(posedge clk);
        cyc++;
        model_edge(we, d, r);
        #1;
        chk("level",    32'(bus.level),    32'(m_q.size()));
        chk("full",     32'(bus.full),     32'(m_q.size() == DEPTH));
        chk("uart_wr",  32'(bus.uart_wr_o), 32'(m_pop_edge == cyc));
        chk("uart_dat", 32'(bus.uart_dat_o), 32'(m_dat));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("tx_busy",  32'(bus.tx_busy),  32'((m_q.size() > 0) || (cyc < m_idle_from - 1)));
        if (bus.uart_wr_o) begin
            s_cyc.push_back(cyc);
            s_byte.push_back(bus.uart_dat_o);
        end
        busy_log[cyc] = bus.tx_busy;
        if (int'(bus.level) > lvl_max) lvl_max = int'(bus.level);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic clr_log();
        s_cyc.delete();
        s_byte.delete();
        lvl_max = 0;
    endtask

    task automatic chk_byte(input string tag, input int i, input logic [7:0] exp);
        chk(tag, (i < s_byte.size()) ? 32'(s_byte[i]) : 32'hFFFF, 32'(exp));
    endtask

    int t0, n0, sent;
    logic [7:0] exp_burst [3];

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_busy",  32'(bus.tx_busy), 0);

        // reset while a frame is in flight
        step(1'b1, 8'h41, 1'b0);
        idle(3);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_level", 32'(bus.level), 0);
        chk("t1_busy",  32'(bus.tx_busy), 0);
        chk("t1_wr",    32'(bus.uart_wr_o), 0);
        chk("t1_dat",   32'(bus.uart_dat_o), 0);
        n0 = s_cyc.size();
        idle(12);
        chk("t1_nostrobe", 32'(s_cyc.size()), 32'(n0));

        // single byte: strobe in the cycle after the pop edge, busy drops 6 edges after push
        clr_log();
        step(1'b1, 8'h48, 1'b0);
        t0 = cyc;
        idle(10);
        chk("t2_count", 32'(s_cyc.size()), 1);
        chk("t2_when",  (s_cyc.size() > 0) ? 32'(s_cyc[0] - t0) : 32'hFFFF, 1);
        chk_byte("t2_byte", 0, 8'h48);
        chk("t2_busy5", 32'(busy_log[t0 + 5]), 1);
        chk("t2_busy6", 32'(busy_log[t0 + 6]), 0);

        // burst of three
        clr_log();
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        idle(24);
        exp_burst[0] = 8'h31; exp_burst[1] = 8'h32; exp_burst[2] = 8'h33;
        chk("t3_count", 32'(s_cyc.size()), 3);
        for (int i = 0; i < 3; i++) chk_byte("t3_byte", i, exp_burst[i]);
        if (s_cyc.size() == 3) begin
            chk("t3_gap0", 32'(s_cyc[1] - s_cyc[0]), 6);
            chk("t3_gap1", 32'(s_cyc[2] - s_cyc[1]), 6);
        end
        chk("t3_peak", 32'(lvl_max), 2);

        // overflow while the sender is busy
        clr_log();
        step(1'b1, 8'hEE, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 8'(k), 1'b0);
            if (k == 4) chk("t4_full", 32'(bus.full), 1);
        end
        chk("t4_ovf", 32'(bus.overflow), 1);
        idle(36);
        chk("t4_count", 32'(s_byte.size()), 5);
        chk_byte("t4_b0", 0, 8'hEE);
        for (int k = 1; k <= 4; k++) chk_byte("t4_b", k, 8'(k));

        // push coinciding with the pop of the last queued byte
        clr_log();
        step(1'b1, 8'hB0, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        chk("t5_level", 32'(bus.level), 1);
        idle(16);
        chk("t5_count", 32'(s_byte.size()), 2);
        chk_byte("t5_b1", 1, 8'hAA);

        // stream ten bytes through the four-entry FIFO, stalling on full
        step(1'b0, 8'h00, 1'b1);
        clr_log();
        sent = 0;
        for (int g = 0; g < 200 && sent < 10; g++) begin
            if (bus.full) step(1'b0, 8'h00, 1'b0);
            else begin
                step(1'b1, 8'(sent), 1'b0);
                sent++;
            end
        end
        chk("t6_pushed", 32'(sent), 10);
        idle(80);
        chk("t6_count", 32'(s_byte.size()), 10);
        for (int i = 0; i < 10; i++) chk_byte("t6_b", i, 8'(i));
        chk("t6_ovf", 32'(bus.overflow), 0);

        // random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
                 8'($urandom),
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        idle(40);
        chk("final_busy", 32'(bus.tx_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
